instr_fetch: RTL and testbench

- Fetch stage directly downstream of program_counter.
- Drives the instruction-memory address from rp and captures the 9-bit instruction word.
- Buffers fetched words in a 2-entry queue and presents them to decode on a valid/ready handshake.
- Back-pressures program_counter with pc_stall and discards wrong-path fetches on redirect.

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instruction-memory read port and the decode valid/ready handshake.
// The fetch stage is the master. Decode and the ROM sit on the slave side.
interface instr_fetch_if #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 9
);
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_rd;
  logic [INSTR_W-1:0] imem_data;
  logic               dec_valid;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;
  logic               dec_ready;

  modport master (
    output imem_addr, imem_rd, dec_valid, dec_instr, dec_pc,
    input  imem_data, dec_ready
  );

  modport slave (
    input  imem_addr, imem_rd, dec_valid, dec_instr, dec_pc,
    output imem_data, dec_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: issues ROM reads at rp and buffers returning words in a 2-entry queue for decode.
// It stalls the PC when the queue plus the in-flight read would overflow, and flushes on redirect.
module instr_fetch #(
  parameter int ADDR_W  = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              start,
  input  logic [ADDR_W-1:0] rp,
  input  logic              redirect,
  instr_fetch_if.master     bus,
  output logic              pc_stall,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [1:0]         occ_q, occ_d;
  logic               inf_q, inf_d;
  logic [ADDR_W-1:0]  inf_pc_q, inf_pc_d;
  logic [INSTR_W-1:0] q_instr_q [2];
  logic [INSTR_W-1:0] q_instr_d [2];
  logic [ADDR_W-1:0]  q_pc_q [2];
  logic [ADDR_W-1:0]  q_pc_d [2];
  logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

  logic       pop;
  logic       issue;
  logic [2:0] level;
  logic [1:0] tail;

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no path leaves it unassigned and no latch is inferred.
    pop   = (occ_q != 2'd0) && bus.dec_ready;
    level = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inf_q};
    issue = !start && !redirect && (level < 3'd2);
    tail  = occ_q - {1'b0, pop};

    occ_d         = occ_q;
    inf_d         = issue;
    inf_pc_d      = inf_pc_q;
    q_instr_d     = q_instr_q;
    q_pc_d        = q_pc_q;
    fetch_count_d = fetch_count_q + CNT_W'(pop);

    if (issue) inf_pc_d = rp;

    if (redirect) begin
      // Wrong-path entries and the in-flight word are dropped. A pop this cycle still counts.
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        q_instr_d[0] = q_instr_q[1];
        q_pc_d[0]    = q_pc_q[1];
      end
      // The issue rule guarantees tail <= 1 whenever a word returns.
      if (inf_q) begin
        q_instr_d[tail[0]] = bus.imem_data;
        q_pc_d[tail[0]]    = inf_pc_q;
      end
      occ_d = tail + {1'b0, inf_q};
    end
  end

  always_ff @(posedge clk or posedge start) begin
    if (start) begin
      occ_q         <= 2'd0;
      inf_q         <= 1'b0;
      inf_pc_q      <= '0;
      // NOTE: the queue storage is reset too, because its head drives dec_instr/dec_pc, which must read 0 in reset.
      q_instr_q[0]  <= '0;
      q_instr_q[1]  <= '0;
      q_pc_q[0]     <= '0;
      q_pc_q[1]     <= '0;
      fetch_count_q <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments, so all flops sample pre-edge values together.
      occ_q         <= occ_d;
      inf_q         <= inf_d;
      inf_pc_q      <= inf_pc_d;
      q_instr_q     <= q_instr_d;
      q_pc_q        <= q_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.imem_addr = rp;
  assign bus.imem_rd   = issue;
  assign bus.dec_valid = (occ_q != 2'd0);
  assign bus.dec_instr = q_instr_q[0];
  assign bus.dec_pc    = q_pc_q[0];
  assign pc_stall      = !start && !redirect && !issue;
  assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC model steps rp unless stalled, and a sync ROM returns ROM[a].
// A second instance with CNT_W=4 checks counter wrap on the same stream.
module tb_instr_fetch;
  localparam int ADDR_W  = 10;
  localparam int INSTR_W = 9;

  logic              clk;
  logic              start;
  logic [ADDR_W-1:0] rp;
  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              pc_stall, pc_stall4;
  logic [15:0]       fetch_count;
  logic [3:0]        fetch_count4;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus  ();
  instr_fetch_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus4 ();

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(16)) u_dut (
    .clk(clk), .start(start), .rp(rp), .redirect(redirect),
    .bus(bus), .pc_stall(pc_stall), .fetch_count(fetch_count)
  );

  instr_fetch #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(4)) u_dut4 (
    .clk(clk), .start(start), .rp(rp), .redirect(redirect),
    .bus(bus4), .pc_stall(pc_stall4), .fetch_count(fetch_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [INSTR_W-1:0] rom(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] s;
    if (a == 10'h040) return 9'h1AB;
    s = 10'h100 + a;
    return s[INSTR_W-1:0];
  endfunction

  always @(posedge clk) begin
    bus.imem_data  <= rom(bus.imem_addr);
    bus4.imem_data <= rom(bus4.imem_addr);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a negedge. Advances to the next negedge, stepping rp like program_counter.
  task automatic cycle();
    logic st;
    st = pc_stall;
    @(posedge clk);
    #1;
    if (!start) begin
      if (redirect)  rp = target;
      else if (!st)  rp = rp + 10'd1;
    end
    redirect = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    start = 1'b1; rp = '0; redirect = 1'b0; target = '0;
    bus.dec_ready = 1'b1; bus4.dec_ready = 1'b1;

    @(negedge clk); #1;
    check("rst_valid", 32'(bus.dec_valid), 0);
    check("rst_count", 32'(fetch_count), 0);
    check("rst_stall", 32'(pc_stall), 0);
    check("rst_rd",    32'(bus.imem_rd), 0);

    // Release start, then stream from address 0.
    start = 1'b0; #1;
    check("n0_rd",    32'(bus.imem_rd), 1);
    check("n0_addr",  32'(bus.imem_addr), 0);
    check("n0_valid", 32'(bus.dec_valid), 0);
    cycle(); #1;
    check("n1_valid", 32'(bus.dec_valid), 0);
    check("n1_addr",  32'(bus.imem_addr), 1);
    cycle(); #1;
    check("n2_valid", 32'(bus.dec_valid), 1);
    check("n2_instr", 32'(bus.dec_instr), 32'h100);
    check("n2_pc",    32'(bus.dec_pc), 0);
    check("n2_count", 32'(fetch_count), 0);
    cycle(); #1;
    check("n3_instr", 32'(bus.dec_instr), 32'h101);
    check("n3_count", 32'(fetch_count), 1);
    cycle(); #1;
    check("n4_instr", 32'(bus.dec_instr), 32'h102);
    cycle(); #1;
    check("n5_count", 32'(fetch_count), 3);
    check("n5_instr", 32'(bus.dec_instr), 32'h103);

    // Decode backs off for 4 cycles.
    bus.dec_ready = 1'b0; #1;
    check("n5_stall", 32'(pc_stall), 1);
    check("n5_rd",    32'(bus.imem_rd), 0);
    cycle(); #1;
    check("n6_stall", 32'(pc_stall), 1);
    check("n6_instr", 32'(bus.dec_instr), 32'h103);
    check("n6_pc",    32'(bus.dec_pc), 3);
    cycle();
    cycle(); #1;
    check("n8_valid", 32'(bus.dec_valid), 1);
    check("n8_instr", 32'(bus.dec_instr), 32'h103);
    check("n8_addr",  32'(bus.imem_addr), 5);
    cycle();
    bus.dec_ready = 1'b1; #1;
    check("n9_stall", 32'(pc_stall), 0);
    check("n9_rd",    32'(bus.imem_rd), 1);
    check("n9_instr", 32'(bus.dec_instr), 32'h103);
    cycle(); #1;
    check("n10_instr", 32'(bus.dec_instr), 32'h104);
    check("n10_pc",    32'(bus.dec_pc), 4);
    check("n10_stall", 32'(pc_stall), 0);
    cycle(); #1;
    check("n11_instr", 32'(bus.dec_instr), 32'h105);
    check("n11_pc",    32'(bus.dec_pc), 5);
    cycle(); #1;
    check("n12_instr", 32'(bus.dec_instr), 32'h106);
    check("n12_count", 32'(fetch_count), 6);

    // Fill the queue, then redirect to 0x040 with no pop.
    bus.dec_ready = 1'b0;
    cycle(); #1;
    check("n13_stall", 32'(pc_stall), 1);
    redirect = 1'b1; target = 10'h040; #1;
    check("n13_redir_stall", 32'(pc_stall), 0);
    check("n13_redir_rd",    32'(bus.imem_rd), 0);
    cycle(); #1;
    check("n14_valid", 32'(bus.dec_valid), 0);
    check("n14_count", 32'(fetch_count), 6);
    check("n14_rd",    32'(bus.imem_rd), 1);
    check("n14_addr",  32'(bus.imem_addr), 32'h040);
    cycle(); #1;
    check("n15_valid", 32'(bus.dec_valid), 0);
    cycle(); #1;
    check("n16_valid", 32'(bus.dec_valid), 1);
    check("n16_instr", 32'(bus.dec_instr), 32'h1AB);
    check("n16_pc",    32'(bus.dec_pc), 32'h040);
    cycle();

    // Redirect in the same cycle as a pop, with a second entry queued.
    bus.dec_ready = 1'b1; redirect = 1'b1; target = 10'h010; #1;
    check("n17_instr", 32'(bus.dec_instr), 32'h1AB);
    check("n17_count", 32'(fetch_count), 6);
    cycle(); #1;
    check("n18_count", 32'(fetch_count), 7);
    check("n18_valid", 32'(bus.dec_valid), 0);
    cycle(); #1;
    check("n19_valid", 32'(bus.dec_valid), 0);
    cycle(); #1;
    check("n20_valid", 32'(bus.dec_valid), 1);
    check("n20_instr", 32'(bus.dec_instr), 32'h110);
    check("n20_pc",    32'(bus.dec_pc), 32'h010);
    check("n20_count", 32'(fetch_count), 7);

    // Fill the queue, then assert start between edges.
    bus.dec_ready = 1'b0;
    cycle(); #1;
    check("n21_stall", 32'(pc_stall), 1);
    start = 1'b1; #1;
    check("ast_valid",  32'(bus.dec_valid), 0);
    check("ast_instr",  32'(bus.dec_instr), 0);
    check("ast_pc",     32'(bus.dec_pc), 0);
    check("ast_count",  32'(fetch_count), 0);
    check("ast_stall",  32'(pc_stall), 0);
    check("ast_rd",     32'(bus.imem_rd), 0);
    check("ast_count4", 32'(fetch_count4), 0);
    rp = 10'h020;
    cycle();
    start = 1'b0; bus.dec_ready = 1'b1; #1;
    check("r0_rd",   32'(bus.imem_rd), 1);
    check("r0_addr", 32'(bus.imem_addr), 32'h020);
    cycle();
    cycle(); #1;
    check("r2_instr", 32'(bus.dec_instr), 32'h120);
    check("r2_pc",    32'(bus.dec_pc), 32'h020);
    cycle(); #1;
    check("r3_instr", 32'(bus.dec_instr), 32'h121);

    // 1 pop per cycle from r2. After k cycles past release, count = k-2.
    for (int k = 3; k < 17; k++) cycle();
    #1;
    check("r17_count4", 32'(fetch_count4), 15);
    cycle(); #1;
    check("r18_count4", 32'(fetch_count4), 0);
    check("r18_count",  32'(fetch_count), 16);
    cycle(); #1;
    check("r19_count4", 32'(fetch_count4), 1);
    check("r19_count",  32'(fetch_count), 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
